// File: rtl/fifo_ctrl.sv
// FIFO control stage: gates producer push/pop requests against the current
// occupancy, drives the memory write/read addresses and reports status and
// sticky error flags. The memory itself lives downstream of this block.
module fifo_ctrl #(
  parameter int MEM_SIZE  = 8,
  parameter int WORD_SIZE = 10,
  parameter int PTR       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_in,
  input  logic                 pop_in,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [PTR:0]         umbral_alto,
  input  logic [PTR:0]         umbral_bajo,
  output logic                 push,
  output logic                 pop,
  output logic [PTR-1:0]       wr_ptr,
  output logic [PTR-1:0]       rd_ptr,
  output logic [WORD_SIZE-1:0] data_in_MM,
  output logic [PTR:0]         count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 valid_out
);

  // Depth expressed on the count width so the full compare is width-matched.
  localparam logic [PTR:0] DEPTH = (PTR+1)'(MEM_SIZE);

  logic [PTR:0] count_inc;
  logic [PTR:0] count_dec;

  // The write word passes straight through to the memory.
  assign data_in_MM = data_in;

  // Status flags decode the registered occupancy; threshold compares are unsigned.
  always_comb begin
    full         = (count == DEPTH);
    empty        = (count == '0);
    almost_full  = (count >= umbral_alto);
    almost_empty = (count <= umbral_bajo);
  end

  // Acceptance: a pop needs data present; a push needs room, or a pop freeing
  // a slot in the same cycle so that full + push + pop keeps streaming.
  always_comb begin
    pop       = pop_in & ~empty;
    push      = push_in & (~full | pop);
    count_inc = {{PTR{1'b0}}, push};
    count_dec = {{PTR{1'b0}}, pop};
  end

  // Pointer, occupancy, read-valid and sticky error registers.
  // Pointers wrap naturally because MEM_SIZE is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR'(push);
      rd_ptr    <= rd_ptr + PTR'(pop);
      count     <= count + count_inc - count_dec;
      valid_out <= pop;
      overflow  <= overflow  | (push_in & ~push);
      underflow <= underflow | (pop_in  & ~pop);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl. A behavioural memory sits on the DUT's
// memory-side outputs; a reference model (integer occupancy plus a queue of
// stored words) predicts every output, and a separate monitor compares the
// memory read data against the expected-word queue whenever valid_out is high.
module tb_fifo_ctrl;

  localparam int MEM_SIZE  = 8;
  localparam int WORD_SIZE = 10;
  localparam int PTR       = 3;

  logic                 clk;
  logic                 reset;
  logic                 push_in;
  logic                 pop_in;
  logic [WORD_SIZE-1:0] data_in;
  logic [PTR:0]         umbral_alto;
  logic [PTR:0]         umbral_bajo;
  logic                 push;
  logic                 pop;
  logic [PTR-1:0]       wr_ptr;
  logic [PTR-1:0]       rd_ptr;
  logic [WORD_SIZE-1:0] data_in_MM;
  logic [PTR:0]         count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow;
  logic                 underflow;
  logic                 valid_out;

  fifo_ctrl #(.MEM_SIZE(MEM_SIZE), .WORD_SIZE(WORD_SIZE), .PTR(PTR)) dut (
    .clk(clk), .reset(reset), .push_in(push_in), .pop_in(pop_in),
    .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push(push), .pop(pop), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .data_in_MM(data_in_MM), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-pointer memory driven by the DUT's memory-side outputs.
  logic [WORD_SIZE-1:0] mem [MEM_SIZE];
  logic [WORD_SIZE-1:0] data_out_MM;
  always @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in_MM;
    if (pop)  data_out_MM <= mem[rd_ptr];
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int                   m_count, m_wr, m_rd;
  bit                   m_ovf, m_udf, m_valid;
  logic [WORD_SIZE-1:0] exp_q [$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every valid read is compared against the oldest expected word.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("read_with_empty_scoreboard", 1, 0);
      end else begin
        checkOutput("data_out_MM", int'(data_out_MM), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock cycle: drive inputs after the falling edge, check every output
  // against the model before the rising edge, then advance the model.
  task automatic applyStimulus(input bit rst_n, input bit p_in, input bit q_in,
                               input logic [WORD_SIZE-1:0] d);
    bit e_push, e_pop, e_full, e_empty;
    @(negedge clk);
    reset   = rst_n;
    push_in = p_in;
    pop_in  = q_in;
    data_in = d;
    #1;
    e_full  = (m_count == MEM_SIZE);
    e_empty = (m_count == 0);
    e_pop   = q_in && !e_empty;
    e_push  = p_in && (!e_full || e_pop);
    checkOutput("push",         int'(push),         int'(e_push));
    checkOutput("pop",          int'(pop),          int'(e_pop));
    checkOutput("count",        int'(count),        m_count);
    checkOutput("wr_ptr",       int'(wr_ptr),       m_wr);
    checkOutput("rd_ptr",       int'(rd_ptr),       m_rd);
    checkOutput("full",         int'(full),         int'(e_full));
    checkOutput("empty",        int'(empty),        int'(e_empty));
    checkOutput("almost_full",  int'(almost_full),  int'(m_count >= int'(umbral_alto)));
    checkOutput("almost_empty", int'(almost_empty), int'(m_count <= int'(umbral_bajo)));
    checkOutput("overflow",     int'(overflow),     int'(m_ovf));
    checkOutput("underflow",    int'(underflow),    int'(m_udf));
    checkOutput("valid_out",    int'(valid_out),    int'(m_valid));
    checkOutput("data_in_MM",   int'(data_in_MM),   int'(d));
    @(posedge clk);
    if (!rst_n) begin
      m_count = 0; m_wr = 0; m_rd = 0;
      m_ovf = 0; m_udf = 0; m_valid = 0;
      exp_q.delete();
    end else begin
      if (e_push) begin
        exp_q.push_back(d);
        m_wr = (m_wr + 1) % MEM_SIZE;
      end
      if (e_pop) m_rd = (m_rd + 1) % MEM_SIZE;
      m_count = m_count + int'(e_push) - int'(e_pop);
      m_valid = e_pop;
      m_ovf   = m_ovf | (p_in && !e_push);
      m_udf   = m_udf | (q_in && !e_pop);
    end
  endtask

  initial begin
    reset = 1'b0; push_in = 1'b0; pop_in = 1'b0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    m_count = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0; m_valid = 0;
    @(posedge clk);

    $display("[TB] reset with requests held high");
    applyStimulus(0, 1, 1, 10'h155);
    applyStimulus(0, 1, 1, 10'h2AA);

    $display("[TB] fill eight words then attempt a ninth");
    for (int i = 1; i <= 8; i++) applyStimulus(1, 1, 0, 10'(i));
    applyStimulus(1, 1, 0, 10'h009);

    $display("[TB] drain eight words then attempt one more pop");
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 10'h000);
    applyStimulus(1, 0, 1, 10'h000);
    applyStimulus(1, 0, 0, 10'h000);

    $display("[TB] refill then simultaneous push and pop while full");
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 10'(10'h040 + i));
    applyStimulus(1, 1, 1, 10'h3FF);
    applyStimulus(1, 1, 1, 10'h3FE);

    $display("[TB] reset, then simultaneous push and pop while empty");
    applyStimulus(0, 0, 0, 10'h000);
    applyStimulus(1, 1, 1, 10'h123);
    applyStimulus(1, 0, 0, 10'h000);

    $display("[TB] interleaved traffic across pointer wrap, thresholds 6/2");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 10'($urandom));
    for (int i = 0; i < 20; i++)
      applyStimulus(1, (i % 3) != 2, (i % 2) == 1, 10'($urandom));
    for (int i = 0; i < 20; i++)
      applyStimulus(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), 10'($urandom));

    $display("[TB] randomized traffic with varied thresholds and occasional reset");
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        umbral_alto = 4'($urandom_range(0, 15));
        umbral_bajo = 4'($urandom_range(0, 15));
      end
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 1) == 1), 10'($urandom));
    end
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 10'h000);
    applyStimulus(1, 0, 0, 10'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
